bch1572_serial_encoder: RTL and testbench

- Bit-serial, LFSR-based systematic BCH(15,7,2) encoder.
- Sits directly upstream of the combinational bch1572_decoder path: it produces the codewords that the channel model corrupts and the decoder consumes.
- Accepts 7-bit data words over a valid/ready handshake and computes the 8 parity bits over K clock cycles.
- Presents the 15-bit codeword on a valid/ready output handshake. Area-lean alternative to the combinational bch1572_encoder.

---
 rtl/bch1572_serial_encoder.sv | 124 ++++++++++++
 tb/tb_bch1572_serial_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bch1572_serial_encoder.sv
// Bit-serial systematic BCH(15,7,2) encoder: one message bit per clock through a parity LFSR.
// Optional build macro BCH_ENC_COUNT_EN adds a saturating word_count of accepted codewords.
`timescale 1ns/1ps

module bch1572_serial_encoder #(
  parameter int               N        = 15,
  parameter int               K        = 7,
  parameter logic [N-K:0]     GEN_POLY = 9'h1D1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_codeword,
`ifdef BCH_ENC_COUNT_EN
  output logic [15:0]      word_count,
`endif
  output logic             busy
);

  localparam int P  = N - K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [K-1:0]    data_q, data_d;
  logic [K-1:0]    shreg_q, shreg_d;
  logic [P-1:0]    lfsr_q, lfsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fb;
  logic            accept;

  // in_ready is forced low while reset is asserted so nothing is taken during reset.
  assign in_ready     = !rst && ((state_q == S_IDLE) || (state_q == S_DONE && out_ready));
  assign accept       = in_valid && in_ready;
  assign out_valid    = (state_q == S_DONE);
  assign busy         = (state_q == S_SHIFT);
  assign out_codeword = out_valid ? {data_q, lfsr_q} : '0;
  assign fb           = shreg_q[K-1] ^ lfsr_q[P-1];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    shreg_d = shreg_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d  = in_data;
          shreg_d = in_data;
          lfsr_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        lfsr_d  = {lfsr_q[P-2:0], 1'b0} ^ (fb ? GEN_POLY[P-1:0] : {P{1'b0}});
        shreg_d = shreg_q << 1;
        if (cnt_q == CW'(K - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // A new word can be loaded on the same edge the codeword leaves.
        if (accept) begin
          data_d  = in_data;
          shreg_d = in_data;
          lfsr_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      shreg_q <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shreg_q <= shreg_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BCH_ENC_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign word_count = count_q;
`endif

endmodule

// File: tb/tb_bch1572_serial_encoder.sv
// Scoreboard bench for bch1572_serial_encoder: directed words, all 128 messages,
// backpressure with back-to-back accept, and reset during SHIFT.
`timescale 1ns/1ps

module tb_bch1572_serial_encoder;

  localparam logic [8:0] GEN = 9'h1D1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_codeword;
  logic        busy;
`ifdef BCH_ENC_COUNT_EN
  logic [15:0] word_count;
`endif

  int errors = 0;
  int checks = 0;
  int n_xfer = 0;
  logic [14:0] exp_q[$];

  bch1572_serial_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
`ifdef BCH_ENC_COUNT_EN
    .word_count   (word_count),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Remainder of a 15-bit polynomial divided by g(x), by long division.
  function automatic logic [7:0] poly_rem(input logic [14:0] cw);
    logic [14:0] v;
    v = cw;
    for (int i = 14; i >= 8; i--) begin
      if (v[i]) v = v ^ (15'(GEN) << (i - 8));
    end
    return v[7:0];
  endfunction

  function automatic logic [14:0] model(input logic [6:0] d);
    return {d, poly_rem({d, 8'h00})};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Offer a word at the current negedge (encoder must be ready) and push its expected codeword.
  task automatic send_word(input logic [6:0] d, input logic [14:0] exp_cw);
    in_valid  = 1'b1;
    in_data   = d;
    check("in_ready_offer", 32'(in_ready), 32'd1);
    exp_q.push_back(exp_cw);
    step();
    in_valid  = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then pop the scoreboard and compare.
  task automatic wait_out(input string tag, input int exp_lat, output logic [14:0] held);
    int lat;
    logic [14:0] e;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h0;
    check({tag, "_codeword"}, 32'(out_codeword), 32'(e));
    check({tag, "_syndrome"}, 32'(poly_rem(out_codeword)), 32'd0);
    $display("xfer %s data=%h codeword=%h expected=%h latency=%0d", tag, out_codeword[14:8],
             out_codeword, e, lat);
    held = e;
  endtask

  task automatic encode_one(input string tag, input logic [6:0] d, input logic [14:0] exp_cw);
    logic [14:0] held;
    out_ready = 1'b1;
    send_word(d, exp_cw);
    wait_out(tag, 7, held);
    step();
    n_xfer++;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [14:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 7'h00;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_codeword", 32'(out_codeword), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    step();

    encode_one("d01", 7'b0000001, 15'h01D1);
    encode_one("d40", 7'b1000000, 15'h40E8);
    encode_one("d7f", 7'h7F, 15'h7FFF);
    encode_one("d00", 7'h00, 15'h0000);

    for (int i = 0; i < 128; i++) begin
      encode_one("all", 7'(i), model(7'(i)));
    end

    // Backpressure: codeword held for 5 stalled cycles with a new word pending.
    out_ready = 1'b1;
    send_word(7'h55, model(7'h55));
    out_ready = 1'b0;
    wait_out("bp_first", 7, held);
    in_valid = 1'b1;
    in_data  = 7'h2A;
    exp_q.push_back(model(7'h2A));
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_codeword_hold", 32'(out_codeword), 32'(held));
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
`ifdef BCH_ENC_COUNT_EN
      check("bp_count_stall", 32'(word_count), 32'(n_xfer));
`endif
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    step();
    n_xfer++;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid_low", 32'(out_valid), 32'd0);
    // Garbage offered while busy must be ignored and must not disturb the latched word.
    in_data = 7'h7F;
    for (int i = 0; i < 3; i++) begin
      check("busy_in_ready_low", 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    in_data  = 7'h11;
    // Three of the seven SHIFT cycles are already spent above.
    wait_out("b2b_second", 4, held);
    step();
    n_xfer++;
    check("b2b_valid_drop", 32'(out_valid), 32'd0);
`ifdef BCH_ENC_COUNT_EN
    check("count_after_bp", 32'(word_count), 32'(n_xfer));
`endif

    // Reset at cnt=3 of SHIFT discards the in-flight word.
    out_ready = 1'b1;
    send_word(7'h33, model(7'h33));
    repeat (3) step();
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    void'(exp_q.pop_back());
    n_xfer = 0;
    step();
    rst = 1'b0;
    step();
    encode_one("post_rst", 7'b0000001, 15'h01D1);
    for (int i = 0; i < 9; i++) begin
      encode_one("count", 7'(i * 13 + 5), model(7'(i * 13 + 5)));
    end
`ifdef BCH_ENC_COUNT_EN
    check("count_ten", 32'(word_count), 32'd10);
`endif
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
